uart_rx_framer: RTL and testbench

- Serial receive front end for the comm path. Recovers 8N1 UART frames from the `rx` pin and presents each byte as `inByte` with a one-cycle `dataReady` strobe.
- Sits directly upstream of `control`, which consumes `dataReady`/`inByte` to fill its buffer.
- Uses oversampled mid-bit sampling, false-start rejection and stop-bit framing checks. Host matrix data arrives over this path.

---
 rtl/comm_pkg.sv | 28 ++
 rtl/baud_tick_gen.sv | 29 ++
 rtl/uart_rx_framer.sv | 188 ++++++++++++++++++
 tb/tb_uart_rx_framer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/comm_pkg.sv
// Shared types and constants for the comm receive path.
// The optional parity feature is enabled with UART_RX_PARITY_EN.
package comm_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    // Clock divisor per oversample tick, rounded to nearest and never below 1.
    function automatic int unsigned calcDiv(
        input int unsigned clkHz,
        input int unsigned baud,
        input int unsigned overSample
    );
        int unsigned den;
        int unsigned quot;
        den  = baud * overSample;
        quot = (clkHz + den / 2) / den;
        return (quot < 1) ? 1 : quot;
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Oversample tick generator: one-cycle tick every DIV clocks, phase reset by clear.
// Used by uart_rx_framer (parity option UART_RX_PARITY_EN does not affect this block).
module baud_tick_gen #(
    parameter int unsigned DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt;
    logic             wrap;

    assign wrap = (cnt == CNT_W'(DIV - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= wrap;
            cnt  <= wrap ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx_framer.sv
// 8N1 UART receiver with oversampled mid-bit sampling and framing checks.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx_framer
    import comm_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned BAUD        = 115200,
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    output logic              dataReady,
    output logic [BYTE_W-1:0] inByte,
    output logic              frameError,
    output logic              parityError,
    output logic              busy
);

    localparam int unsigned DIV       = calcDiv(CLK_FREQ_HZ, BAUD, OVERSAMPLE);
    localparam int unsigned SAMPLE_W  = $clog2(OVERSAMPLE);
    localparam int unsigned HALF      = OVERSAMPLE / 2;
    localparam int unsigned BIT_IDX_W = $clog2(BYTE_W);

    rx_state_t              state;
    rx_state_t              nextState;
    logic [SYNC_STAGES-1:0] syncQ;
    logic                   rxSync;
    logic                   prevRx;
    logic                   tick;
    logic [SAMPLE_W-1:0]    sampleCnt;
    logic [BIT_IDX_W-1:0]   bitIdx;
    logic [BYTE_W-1:0]      shiftReg;

    logic startDetect;
    logic midStart;
    logic bitEnd;
    logic lastBit;
    logic parityBad;
    logic sampleClr;
    logic shiftEn;
    logic readyNext;
    logic frameErrNext;
    logic parityErrNext;

    assign rxSync      = syncQ[SYNC_STAGES-1];
    assign startDetect = (state == IDLE) && prevRx && !rxSync;
    assign midStart    = tick && (state == START) && (sampleCnt == SAMPLE_W'(HALF - 1));
    assign bitEnd      = tick && (sampleCnt == SAMPLE_W'(OVERSAMPLE - 1));
    assign lastBit     = (bitIdx == BIT_IDX_W'(BYTE_W - 1));

`ifdef UART_RX_PARITY_EN
    logic parityBit;
    logic parityEn;
    assign parityBad = (^shiftReg) ^ parityBit;
`else
    assign parityBad = 1'b0;
`endif

    baud_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .clear (startDetect),
        .tick  (tick)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic
    always_comb begin
        nextState = state;
        case (state)
            IDLE:   if (startDetect) nextState = START;
            START:  if (midStart) nextState = rxSync ? IDLE : DATA;
            DATA: begin
                if (bitEnd && lastBit) begin
`ifdef UART_RX_PARITY_EN
                    nextState = PARITY;
`else
                    nextState = STOP;
`endif
                end
            end
            PARITY: if (bitEnd) nextState = STOP;
            STOP:   if (bitEnd) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Datapath controls and next values of the result strobes
    always_comb begin
        sampleClr     = startDetect;
        shiftEn       = 1'b0;
        readyNext     = 1'b0;
        frameErrNext  = 1'b0;
        parityErrNext = 1'b0;
`ifdef UART_RX_PARITY_EN
        parityEn      = 1'b0;
`endif
        case (state)
            START: sampleClr = midStart && !rxSync;
            DATA:  shiftEn   = bitEnd;
            PARITY: begin
`ifdef UART_RX_PARITY_EN
                parityEn = bitEnd;
`endif
            end
            STOP: begin
                // A bad stop bit outranks a parity mismatch
                if (bitEnd) begin
                    if (!rxSync) begin
                        frameErrNext = 1'b1;
                    end else if (parityBad) begin
                        parityErrNext = 1'b1;
                    end else begin
                        readyNext = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            syncQ       <= '1;
            prevRx      <= 1'b1;
            sampleCnt   <= '0;
            bitIdx      <= '0;
            shiftReg    <= '0;
            inByte      <= '0;
            dataReady   <= 1'b0;
            frameError  <= 1'b0;
            parityError <= 1'b0;
            busy        <= 1'b0;
        end else begin
            syncQ  <= {syncQ[SYNC_STAGES-2:0], rx};
            prevRx <= rxSync;

            if (sampleClr) begin
                sampleCnt <= '0;
            end else if (tick && (state != IDLE)) begin
                sampleCnt <= (sampleCnt == SAMPLE_W'(OVERSAMPLE - 1)) ? '0
                                                                      : sampleCnt + SAMPLE_W'(1);
            end

            if (sampleClr) begin
                bitIdx <= '0;
            end else if (shiftEn) begin
                bitIdx <= bitIdx + BIT_IDX_W'(1);
            end

            if (shiftEn) begin
                shiftReg <= {rxSync, shiftReg[BYTE_W-1:1]};
            end

            if (readyNext) begin
                inByte <= shiftReg;
            end

            dataReady   <= readyNext;
            frameError  <= frameErrNext;
            parityError <= parityErrNext;
            busy        <= (nextState != IDLE);
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            parityBit <= 1'b0;
        end else if (parityEn) begin
            parityBit <= rxSync;
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_framer.sv
// Bench for uart_rx_framer: directed frames plus random frames against a frame-level model.
// Honours UART_RX_PARITY_EN by inserting an even-parity bit in every generated frame.
module tb_uart_rx_framer;
    import comm_pkg::*;

    localparam int unsigned CLK_HZ = 1_600_000;
    localparam int unsigned BAUD_R = 10_000;
    localparam int unsigned OS     = 16;
    localparam int unsigned SYNC   = 2;
    localparam int          DIVV   = 10;
    localparam int          BIT    = 160;
`ifdef UART_RX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif
    localparam int FRAME_N = 10 + PBITS;
    localparam int LAT_LO  = (19 * BIT) / 2 + PBITS * BIT - (OS * DIVV) / 2;
    localparam int LAT_HI  = (19 * BIT) / 2 + PBITS * BIT + DIVV + SYNC + 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       dataReady;
    logic [7:0] inByte;
    logic       frameError;
    logic       parityError;
    logic       busy;

    uart_rx_framer #(
        .CLK_FREQ_HZ (CLK_HZ),
        .BAUD        (BAUD_R),
        .OVERSAMPLE  (OS),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .dataReady   (dataReady),
        .inByte      (inByte),
        .frameError  (frameError),
        .parityError (parityError),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed events, sampled on the falling edge
    logic [7:0] gotQ[$];
    int readyCnt = 0;
    int feCnt = 0;
    int peCnt = 0;
    int multiHot = 0;
    int busyCnt = 0;
    int lastReadyCyc = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (dataReady) begin
                gotQ.push_back(inByte);
                readyCnt++;
                lastReadyCyc = cyc;
            end
            if (frameError) feCnt++;
            if (parityError) peCnt++;
            if ((int'(dataReady) + int'(frameError) + int'(parityError)) > 1) multiHot++;
            if (busy) busyCnt++;
        end
    end

    int total = 0;
    int bad = 0;
    int startCyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic checkRange(input string tag, input int val, input int lo, input int hi);
        total++;
        assert (val >= lo && val <= hi) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, val, lo, hi);
        end
    endtask

    // Frame as sent on the wire, LSB first: start, data, [even parity], stop
    function automatic logic [15:0] mkFrame(input logic [7:0] b, input logic stopBit);
`ifdef UART_RX_PARITY_EN
        return 16'({stopBit, ^b, b, 1'b0});
`else
        return 16'({stopBit, b, 1'b0});
`endif
    endfunction

    task automatic sendRaw(input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            rx = bits[i];
            if (i == 0) startCyc = cyc;
            repeat (BIT) @(negedge clk);
        end
    endtask

    task automatic sendFrame(input logic [7:0] b, input logic stopBit);
        sendRaw(mkFrame(b, stopBit), FRAME_N);
    endtask

    task automatic idle(input int nBits);
        rx = 1'b1;
        repeat (nBits * BIT) @(negedge clk);
    endtask

    int r0, f0, p0, b0, q0, expFe, gap;
    logic [7:0] expQ[$];
    logic [7:0] rb;
    logic [15:0] bits;
    logic good, prevBad;

    initial begin
        rx    = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check("rst_dataReady", 32'(dataReady), 32'd0);
        check("rst_inByte", 32'(inByte), 32'h00);
        check("rst_frameError", 32'(frameError), 32'd0);
        check("rst_parityError", 32'(parityError), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        idle(1);

        // Single byte, with start-to-strobe latency
        r0 = readyCnt; b0 = busyCnt;
        sendFrame(8'hA5, 1'b1);
        check("basic_count", 32'(readyCnt - r0), 32'd1);
        check("basic_byte", 32'(inByte), 32'hA5);
        check("basic_fe", 32'(feCnt), 32'd0);
        check("basic_busy_seen", 32'(busyCnt > b0), 32'd1);
        check("basic_busy_end", 32'(busy), 32'd0);
        checkRange("basic_latency", lastReadyCyc - startCyc, LAT_LO, LAT_HI);
        idle(1);

        // Back-to-back frames with no idle bit
        q0 = gotQ.size();
        sendFrame(8'h00, 1'b1);
        sendFrame(8'hFF, 1'b1);
        idle(1);
        check("b2b_count", 32'(gotQ.size() - q0), 32'd2);
        check("b2b_first", (gotQ.size() > q0) ? 32'(gotQ[q0]) : 32'hFFFF_FFFF, 32'h00);
        check("b2b_second", (gotQ.size() > q0 + 1) ? 32'(gotQ[q0 + 1]) : 32'hFFFF_FFFF, 32'hFF);
        check("b2b_fe", 32'(feCnt), 32'd0);

        // Short low glitch is rejected as a false start
        r0 = readyCnt; b0 = busyCnt;
        rx = 1'b0;
        repeat (40) @(negedge clk);
        idle(2);
        check("glitch_no_ready", 32'(readyCnt - r0), 32'd0);
        check("glitch_busy_seen", 32'(busyCnt > b0), 32'd1);
        check("glitch_busy_end", 32'(busy), 32'd0);
        check("glitch_state", 32'(dut.state), 32'(IDLE));
        sendFrame(8'h5A, 1'b1);
        idle(1);
        check("glitch_next_count", 32'(readyCnt - r0), 32'd1);
        check("glitch_next_byte", 32'(inByte), 32'h5A);

        // Stop bit 0 raises frameError and keeps the previous byte
        sendFrame(8'hA5, 1'b1);
        idle(1);
        r0 = readyCnt; f0 = feCnt;
        sendFrame(8'h3C, 1'b0);
        check("fe_pulse", 32'(feCnt - f0), 32'd1);
        check("fe_no_ready", 32'(readyCnt - r0), 32'd0);
        check("fe_byte_held", 32'(inByte), 32'hA5);
        b0 = busyCnt;
        repeat (2 * BIT) @(negedge clk);
        check("fe_low_no_rearm", 32'(busyCnt - b0), 32'd0);
        idle(1);
        sendFrame(8'h3C, 1'b1);
        idle(1);
        check("fe_recover_count", 32'(readyCnt - r0), 32'd1);
        check("fe_recover_byte", 32'(inByte), 32'h3C);

        // Reset in the middle of data bit 4 discards the frame
        r0 = readyCnt; f0 = feCnt;
        bits = mkFrame(8'hC3, 1'b1);
        for (int i = 0; i < 5; i++) begin
            rx = bits[i];
            repeat (BIT) @(negedge clk);
        end
        rx = bits[5];
        repeat (BIT / 2) @(negedge clk);
        reset = 1'b1;
        rx    = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_inByte", 32'(inByte), 32'h00);
        idle(1);
        sendFrame(8'h81, 1'b1);
        idle(1);
        check("rstmid_count", 32'(readyCnt - r0), 32'd1);
        check("rstmid_byte", 32'(inByte), 32'h81);
        check("rstmid_fe", 32'(feCnt - f0), 32'd0);

`ifdef UART_RX_PARITY_EN
        // 0x07 has odd weight, so even parity needs a 1
        r0 = readyCnt; p0 = peCnt;
        sendRaw(16'({1'b1, 1'b0, 8'h07, 1'b0}), 11);
        idle(1);
        check("par_bad_pulse", 32'(peCnt - p0), 32'd1);
        check("par_bad_no_ready", 32'(readyCnt - r0), 32'd0);
        check("par_bad_byte_held", 32'(inByte), 32'h81);
        sendRaw(16'({1'b1, 1'b1, 8'h07, 1'b0}), 11);
        idle(1);
        check("par_ok_count", 32'(readyCnt - r0), 32'd1);
        check("par_ok_byte", 32'(inByte), 32'h07);
`endif

        // Random frames with random stop validity and gaps
        q0 = gotQ.size(); f0 = feCnt; p0 = peCnt;
        expFe = 0; prevBad = 1'b0;
        for (int k = 0; k < 12; k++) begin
            rb   = 8'($urandom);
            good = ($urandom_range(0, 3) != 0);
            gap  = prevBad ? int'($urandom_range(1, 2)) : int'($urandom_range(0, 2));
            if (gap > 0) idle(gap);
            sendFrame(rb, good);
            if (good) expQ.push_back(rb);
            else expFe++;
            prevBad = !good;
        end
        idle(1);
        check("rand_count", 32'(gotQ.size() - q0), 32'(expQ.size()));
        for (int i = 0; i < expQ.size(); i++) begin
            check("rand_byte", (gotQ.size() > q0 + i) ? 32'(gotQ[q0 + i]) : 32'hFFFF_FFFF,
                  32'(expQ[i]));
        end
        if (expQ.size() > 0) check("rand_last_byte", 32'(inByte), 32'(expQ[expQ.size() - 1]));
        check("rand_fe", 32'(feCnt - f0), 32'(expFe));
        check("rand_pe", 32'(peCnt - p0), 32'd0);
        check("strobe_exclusive", 32'(multiHot), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
